// File: rtl/dsp_seq_ctrl_pkg.sv
// Shared widths, job/state encodings and DSP mode constants for the DSP sequencer.
package dsp_seq_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH    = 5;
  localparam int unsigned ALUMODE_WIDTH = 4;
  localparam int unsigned OPMODE_WIDTH  = 7;
  localparam int unsigned INMODE_WIDTH  = 5;
  localparam int unsigned DRAIN_CYCLES  = 4;
  localparam int unsigned DRAIN_W       = $clog2(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_MAC = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_MUL     = 7'h05;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_MAC     = 7'h25;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_ADDSUB  = 7'h33;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ADD    = 4'h0;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_SUB    = 4'h3;
  localparam logic [INMODE_WIDTH-1:0]  INMODE_DEFAULT = 5'h00;

  // MAC seeds the accumulator with a plain multiply on its first element.
  function automatic logic [OPMODE_WIDTH-1:0] opmode_for(input op_e op, input logic first_elem);
    logic [OPMODE_WIDTH-1:0] m;
    m = OPMODE_ADDSUB;
    if (op == OP_MUL) m = OPMODE_MUL;
    else if (op == OP_MAC) m = first_elem ? OPMODE_MUL : OPMODE_MAC;
    return m;
  endfunction

endpackage

// File: rtl/dsp_seq_ctrl.sv
// Job sequencer: walks operand addresses, issues result writes and DSP mode
// controls with write-side timing, then drains the pipeline before signalling done.
module dsp_seq_ctrl
  import dsp_seq_ctrl_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               op_sel_i,
  input  logic [ADDR_WIDTH-1:0]    len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     bram0_en_o,
  output logic [ADDR_WIDTH-1:0]    bram0_r_addr_o,
  output logic                     bram1_web_o,
  output logic [ADDR_WIDTH-1:0]    bram1_w_addr_o,
  output logic [ALUMODE_WIDTH-1:0] alumode_o,
  output logic [OPMODE_WIDTH-1:0]  opmode_o,
  output logic [INMODE_WIDTH-1:0]  inmode_o
);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [ADDR_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    bram0_en_o     = 1'b0;
    bram0_r_addr_o = '0;
    bram1_web_o    = 1'b0;
    bram1_w_addr_o = '0;
    alumode_o      = '0;
    opmode_o       = '0;
    inmode_o       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_e'(op_sel_i);
          len_d   = len_i;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o         = 1'b1;
        bram0_en_o     = 1'b1;
        bram0_r_addr_o = cnt_q;
        opmode_o       = opmode_for(op_q, cnt_q == '0);
        alumode_o      = (op_q == OP_SUB) ? ALUMODE_SUB : ALUMODE_ADD;
        inmode_o       = INMODE_DEFAULT;
        if (op_q == OP_MAC) begin
          bram1_web_o    = (cnt_q == len_q);
          bram1_w_addr_o = '0;
        end else begin
          bram1_web_o    = 1'b1;
          bram1_w_addr_o = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        // Counter is cleared on exit, so len=31 never wraps onto a live address.
        if (cnt_q == len_q) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_o  = 1'b1;
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsp_seq_ctrl.sv
// Self-checking bench for dsp_seq_ctrl: directed scenarios plus randomized jobs
// compared cycle by cycle against a per-job trace model.
module tb_dsp_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [1:0] op_sel_i;
  logic [4:0] len_i;
  logic       busy_o, done_o, bram0_en_o, bram1_web_o;
  logic [4:0] bram0_r_addr_o, bram1_w_addr_o;
  logic [3:0] alumode_o;
  logic [6:0] opmode_o;
  logic [4:0] inmode_o;

  int checks = 0;
  int errors = 0;

  dsp_seq_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .op_sel_i       (op_sel_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .bram0_en_o     (bram0_en_o),
    .bram0_r_addr_o (bram0_r_addr_o),
    .bram1_web_o    (bram1_web_o),
    .bram1_w_addr_o (bram1_w_addr_o),
    .alumode_o      (alumode_o),
    .opmode_o       (opmode_o),
    .inmode_o       (inmode_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [29:0] observed();
    return {busy_o, done_o, bram0_en_o, bram0_r_addr_o, bram1_web_o, bram1_w_addr_o,
            alumode_o, opmode_o, inmode_o};
  endfunction

  // Expected outputs k cycles after the accepting edge of a job (op, len).
  function automatic logic [29:0] model(input int op, input int len, input int k);
    logic       busy, done, en, web;
    logic [4:0] ra, wa;
    logic [3:0] alu;
    logic [6:0] opm;
    busy = 0; done = 0; en = 0; web = 0; ra = 0; wa = 0; alu = 0; opm = 0;
    if (k >= 1 && k <= len + 1) begin
      busy = 1; en = 1; ra = 5'(k - 1);
      alu  = (op == 3) ? 4'h3 : 4'h0;
      if (op == 1) begin
        web = (k - 1 == len);
        wa  = 0;
        opm = (k == 1) ? 7'h05 : 7'h25;
      end else begin
        web = 1;
        wa  = 5'(k - 1);
        opm = (op == 0) ? 7'h05 : 7'h33;
      end
    end else if (k > len + 1 && k <= len + 5) begin
      busy = 1;
    end else if (k == len + 6) begin
      done = 1;
    end
    return {busy, done, en, ra, web, wa, alu, opm, 5'h00};
  endfunction

  // Present a start pulse and return #1 after the accepting edge; job inputs are
  // then scrambled to show the latched values stay put.
  task automatic launch(input int op, input int len, input bit hold);
    start_i  = 1'b1;
    op_sel_i = 2'(op);
    len_i    = 5'(len);
    @(posedge clk_i); #1;
    start_i  = hold;
    op_sel_i = 2'($urandom);
    len_i    = 5'($urandom);
  endtask

  task automatic run_directed(input string name, input int op, input int len);
    logic [29:0] exp;
    launch(op, len, 1'b0);
    for (int k = 1; k <= len + 7; k++) begin
      exp = model(op, len, k);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got %h exp %h", name, k, observed(), exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; op_sel_i = 2'd0; len_i = 5'd3;
    #1;
    checks++;
    if (observed() !== 30'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", observed(), 30'h0);
    end
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (observed() !== 30'h0) begin
      errors++;
      $display("FAIL reset_held got %h exp %h", observed(), 30'h0);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (observed() !== 30'h0) begin
      errors++;
      $display("FAIL idle_after_reset got %h exp %h", observed(), 30'h0);
    end
  endtask

  task automatic test_mul(); run_directed("mul_len3", 0, 3); endtask
  task automatic test_mac(); run_directed("mac_len4", 1, 4); endtask
  task automatic test_sub(); run_directed("sub_len0", 3, 0); endtask

  task automatic test_random();
    logic [29:0] exp;
    int op, len;
    for (int j = 0; j < 12; j++) begin
      op  = int'($urandom_range(0, 3));
      len = (j == 0) ? 31 : int'($urandom_range(0, 31));
      launch(op, len, 1'b0);
      for (int k = 1; k <= len + 7; k++) begin
        exp = model(op, len, k);
        checks++;
        if (observed() !== exp) begin
          errors++;
          $display("FAIL random op=%0d len=%0d k=%0d got %h exp %h", op, len, k, observed(), exp);
        end
        start_i = (k < len + 6) ? 1'($urandom) : 1'b0;
        @(posedge clk_i); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp;
    int op2, len2;
    op2  = int'($urandom_range(0, 3));
    len2 = int'($urandom_range(0, 31));
    launch(2, 31, 1'b1);
    for (int k = 1; k <= 38; k++) begin
      exp = model(2, 31, k);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL b2b_first k=%0d got %h exp %h", k, observed(), exp);
      end
      if (k == 37) begin
        op_sel_i = 2'(op2);
        len_i    = 5'(len2);
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    for (int k = 1; k <= len2 + 7; k++) begin
      exp = model(op2, len2, k);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL b2b_second k=%0d got %h exp %h", k, observed(), exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset_mid_job();
    logic [29:0] exp;
    int op;
    op = int'($urandom_range(0, 3));
    launch(op, 10, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      exp = model(op, 10, k);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL midrst_pre k=%0d got %h exp %h", k, observed(), exp);
      end
      if (k < 3) begin
        @(posedge clk_i); #1;
      end
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (observed() !== 30'h0) begin
      errors++;
      $display("FAIL midrst_same_cycle got %h exp %h", observed(), 30'h0);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (c == 2) rst_i = 1'b0;
      checks++;
      if (observed() !== 30'h0) begin
        errors++;
        $display("FAIL midrst_no_done c=%0d got %h exp %h", c, observed(), 30'h0);
      end
    end
    rst_i = 1'b1;
    #1;
    start_i = 1'b1; op_sel_i = 2'd1; len_i = 5'd2;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp = model(1, 2, k);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL midrst_restart k=%0d got %h exp %h", k, observed(), exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_sel_i = '0; len_i = '0;
    test_reset();
    test_mul();
    test_mac();
    test_sub();
    test_random();
    test_back_to_back();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
